// File: rtl/deser_arbiter.sv
// Round-robin frame arbiter feeding NUM_CH word streams into one deserializer.
// Optional stall abort is enabled by defining DESER_ARB_TIMEOUT_EN.
module deser_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4,
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [NUM_CH*WIDTH-1:0]   i_data,
  input  logic [NUM_CH-1:0]         i_dv,
  output logic [NUM_CH-1:0]         o_ready,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_owner,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_dv,
  output logic                      o_flush
);

  localparam int IW = $clog2(NUM_CH);
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 1 || NUM_WORDS < 1) begin : g_bad_params
    $error("deser_arbiter: illegal parameter set");
  end

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     w_sel_idx;
  logic [IW-1:0]     w_ptr_nxt;
  logic [IW:0]       w_j;
  logic [NUM_CH-1:0] r_grant;
  logic [NUM_CH-1:0] w_sel_onehot;
  logic              w_sel_found;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  w_word;
  logic [IW-1:0]     r_owner;
  logic              r_dv;
  logic              w_accept;
  logic              w_last;
  logic              w_timeout;

  // First requester at or above r_ptr, wrapping modulo NUM_CH.
  always_comb begin
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    w_sel_found  = 1'b0;
    w_j          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_j = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_j >= (IW+1)'(NUM_CH)) w_j = w_j - (IW+1)'(NUM_CH);
      if (!w_sel_found && i_req[w_j[IW-1:0]]) begin
        w_sel_found                 = 1'b1;
        w_sel_idx                   = w_j[IW-1:0];
        w_sel_onehot[w_j[IW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_gidx == IW'(k)) w_word = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_accept  = |(i_dv & o_ready);
  assign w_last    = w_accept && (r_cnt == CW'(NUM_WORDS-1));
  assign w_ptr_nxt = (r_gidx == IW'(NUM_CH-1)) ? '0 : r_gidx + IW'(1);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|i_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_BUSY) ? r_grant : '0;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_owner <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= w_accept;
      if (w_accept) begin
        r_data  <= w_word;
        r_owner <= r_gidx;
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end
      if (r_state == S_IDLE) begin
        if (|i_req) begin
          r_grant <= w_sel_onehot;
          r_gidx  <= w_sel_idx;
        end
      end else if (w_last || w_timeout) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_nxt;
        r_cnt   <= '0;
      end
    end
  end

  assign o_grant = r_grant;
  assign o_owner = r_owner;
  assign o_data  = r_data;
  assign o_dv    = r_dv;

`ifdef DESER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_idle;
  logic          r_flush;

  // Abort on the TIMEOUT-th consecutive busy cycle without an accepted word.
  assign w_timeout = (r_state == S_BUSY) && !w_accept && (r_idle == TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_idle  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_timeout;
      if (r_state != S_BUSY || w_accept || w_timeout) r_idle <= '0;
      else                                            r_idle <= r_idle + TW'(1);
    end
  end

  assign o_flush = r_flush;
`else
  assign w_timeout = 1'b0;
  assign o_flush   = 1'b0;
`endif

endmodule

// File: tb/tb_deser_arbiter.sv
// Directed bench for deser_arbiter: stream driver, word scoreboard, grant/reset checks.
module tb_deser_arbiter;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int OW    = 2;
  localparam int W     = OW + WIDTH;

  logic              clk;
  logic              i_reset;
  logic [NCH-1:0]    i_req;
  logic [NCH*WIDTH-1:0] i_data;
  logic [NCH-1:0]    i_dv;
  logic [NCH-1:0]    o_ready;
  logic [NCH-1:0]    o_grant;
  logic [OW-1:0]     o_owner;
  logic [WIDTH-1:0]  o_data;
  logic              o_dv;
  logic              o_flush;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           failures;
  logic [NCH-1:0] dv_en;
  bit           mode;
  int           sent [NCH];
  logic [NCH-1:0] acc;

  deser_arbiter #(.WIDTH(WIDTH), .NUM_WORDS(4), .NUM_CH(NCH), .TIMEOUT(16)) dut (
    .clk(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data), .i_dv(i_dv),
    .o_ready(o_ready), .o_grant(o_grant), .o_owner(o_owner), .o_data(o_data),
    .o_dv(o_dv), .o_flush(o_flush)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] word_of(input int ch, input int n, input bit m);
    logic [WIDTH-1:0] v;
    if (m) v = WIDTH'(8'h11 * (n + 1));
    else   v = {4'(ch), 4'(n)};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int ch, input int n0, input int cnt);
    for (int n = n0; n < n0 + cnt; n++) exp_q.push_back({OW'(ch), word_of(ch, n, mode)});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 0);
    check({tag, "_ready"}, 32'(o_ready), 0);
    check({tag, "_data"},  32'(o_data),  0);
    check({tag, "_dv"},    32'(o_dv),    0);
    check({tag, "_owner"}, 32'(o_owner), 0);
    check({tag, "_flush"}, 32'(o_flush), 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check({tag, "_drain"}, 32'(exp_q.size()), 0);
  endtask

  // driver: each enabled channel streams word_of(ch, words accepted so far)
  initial begin
    i_dv   = '0;
    i_data = '0;
    acc    = '0;
    for (int c = 0; c < NCH; c++) sent[c] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (i_reset) sent[c] = 0;
        else if (acc[c]) sent[c]++;
        i_data[c*WIDTH +: WIDTH] = word_of(c, sent[c], mode);
      end
      i_dv = dv_en;
      acc  = i_reset ? '0 : (dv_en & o_ready);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (o_dv === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got owner=%0d data=%0h expected no word", o_owner, o_data);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'({o_owner, o_data}), 32'(e));
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [NCH-1:0] eg;
    int p;
    checks = 0; failures = 0;
    i_reset = 1'b1; i_req = '0; dv_en = '0; mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    i_reset = 1'b0;

    // single channel frame, request dropped mid-frame
    dv_en = 4'b0001;
    push_frame(0, 0, 4);
    i_req = 4'b0001;
    tick();
    check("t1_grant_c1", 32'(o_grant), 32'h1);
    check("t1_ready_c1", 32'(o_ready), 32'h1);
    i_req = '0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("t1_grant_held", 32'(o_grant), 32'h1);
    end
    tick();
    check("t1_grant_end", 32'(o_grant), 0);
    check("t1_ready_end", 32'(o_ready), 0);
    dv_en = '0;
    wait_drain("t1");
    mode = 1'b0;
    i_reset = 1'b1;
    repeat (2) tick();
    i_reset = 1'b0;

    // all channels requesting and streaming
    dv_en = 4'b1111;
    push_frame(0, 0, 4); push_frame(1, 0, 4); push_frame(2, 0, 4);
    push_frame(3, 0, 4); push_frame(0, 4, 4);
    i_req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      tick();
      p  = (c - 1) % 5;
      eg = (p < 4) ? NCH'(1 << (((c - 1) / 5) % 4)) : '0;
      check("t2_grant", 32'(o_grant), 32'(eg));
      if (c == 25) i_req = '0;
    end
    dv_en = '0;
    wait_drain("t2");

    // ch2 then wrap to ch0; ch1 strobes ignored
    dv_en = 4'b0111;
    push_frame(2, 4, 4); push_frame(0, 8, 4);
    i_req = 4'b0101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 4)      eg = 4'b0100;
      else if (c == 5) eg = 4'b0000;
      else if (c <= 9) eg = 4'b0001;
      else             eg = 4'b0000;
      check("t3_grant", 32'(o_grant), 32'(eg));
      if (c == 10) i_req = '0;
    end
    dv_en = '0;
    wait_drain("t3");

    // reset mid-frame, then ch3 frame from pointer 0
    dv_en = 4'b1000;
    push_frame(3, 4, 2);
    i_req = 4'b1000;
    tick();
    check("t4_grant_c1", 32'(o_grant), 32'h8);
    tick();
    tick();
    @(negedge clk);
    #1;
    i_reset = 1'b1;
    #1;
    check_zero("t4_midreset");
    tick();
    tick();
    i_reset = 1'b0;
    push_frame(3, 0, 4);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t4_grant", 32'(o_grant), (c < 5) ? 32'h8 : 32'h0);
      if (c == 5) i_req = '0;
    end
    dv_en = '0;
    wait_drain("t4");

    // ch1 stalls after one word while ch2 waits
    dv_en = 4'b0110;
    push_frame(1, 0, 1);
    i_req = 4'b0110;
    tick();
    check("t5_grant_c1", 32'(o_grant), 32'h2);
    tick();
    dv_en = 4'b0100;
    i_req = 4'b0100;
`ifdef DESER_ARB_TIMEOUT_EN
    push_frame(2, 0, 4);
    for (int c = 2; c <= 17; c++) begin
      if (c > 2) tick();
      check("t5_flush_low", 32'(o_flush), 0);
      check("t5_grant_stall", 32'(o_grant), 32'h2);
    end
    tick();
    check("t5_flush_pulse", 32'(o_flush), 1);
    check("t5_grant_abort", 32'(o_grant), 0);
    tick();
    check("t5_flush_done", 32'(o_flush), 0);
    check("t5_grant_next", 32'(o_grant), 32'h4);
    i_req = '0;
`else
    push_frame(1, 1, 3);
    push_frame(2, 0, 4);
    for (int c = 2; c <= 21; c++) begin
      if (c > 2) tick();
      check("t5_flush_low", 32'(o_flush), 0);
      check("t5_grant_stall", 32'(o_grant), 32'h2);
    end
    tick();
    dv_en = 4'b0110;
    for (int i = 0; i < 20 && o_grant !== 4'b0100; i++) tick();
    check("t5_grant_next", 32'(o_grant), 32'h4);
    i_req = '0;
`endif
    wait_drain("t5");
    dv_en = '0;
    repeat (3) tick();
    check("final_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deser_arbiter.md
DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter NUM_WORDS, default 4, SHALL set the words per frame, matching the downstream deserializer.
REQ-003 Parameter NUM_CH, default 4, SHALL set the number of requesters (2..16).
REQ-004 Parameter TIMEOUT, default 16, SHALL set the idle-cycle abort limit (used only with DESER_ARB_TIMEOUT_EN).
REQ-005 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 i_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 i_req  in  NUM_CH  SHALL carry the per-channel frame request.
REQ-008 i_data  in  NUM_CH*WIDTH  SHALL carry the per-channel words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 i_dv  in  NUM_CH  SHALL carry the per-channel word-valid.
REQ-010 o_ready  out  NUM_CH  SHALL indicate the per-channel accept; only the granted bit may be 1.
REQ-011 o_grant  out  NUM_CH  SHALL be the one-hot current owner, or all-zero when idle.
REQ-012 o_owner  out  $clog2(NUM_CH)  SHALL be the binary index of the owner of the word on o_data.
REQ-013 o_data  out  WIDTH  SHALL be the registered word to the deserializer i_data.
REQ-014 o_dv  out  1  SHALL be the registered word-valid to the deserializer i_dv.
REQ-015 o_flush  out  1  SHALL be a one-cycle pulse that resets a partially filled deserializer.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-017 In IDLE with any i_req bit set, the block SHALL select the first set bit searching upward from pointer ptr (mod NUM_CH), load o_grant, and enter BUSY on the next edge.
REQ-018 o_ready SHALL equal o_grant while BUSY and SHALL be all-zero in IDLE.
REQ-019 A word SHALL be accepted when i_dv[g] & o_ready[g]; i_dv on non-granted channels SHALL be ignored.
REQ-020 Each accepted word SHALL appear on o_data/o_dv/o_owner exactly one cycle later; o_dv SHALL be 0 otherwise.
REQ-021 The word counter SHALL count 0..NUM_WORDS-1 and clear on the last accepted word of a frame.
REQ-022 On the last accepted word, the block SHALL enter IDLE and clear o_grant on the next edge, and SHALL set ptr = (g+1) mod NUM_CH, wrapping NUM_CH-1 to 0.
REQ-023 Grant SHALL be held for the full frame even if i_req[g] drops mid-frame.
REQ-024 Frames SHALL be separated by at least one IDLE (arbitration) cycle.
REQ-025 Simultaneous requests SHALL be resolved round-robin per REQ-017, with no channel starved beyond NUM_CH-1 frames.

Reset
REQ-026 Asserting i_reset SHALL immediately force state=IDLE, ptr=0, counter=0, o_grant=0, o_ready=0, o_data=0, o_dv=0, o_owner=0 and o_flush=0, including mid-frame.
REQ-027 The first arbitration after reset release SHALL give priority to channel 0.

Configuration
REQ-028 With macro DESER_ARB_TIMEOUT_EN defined, the block SHALL count consecutive BUSY cycles with no accepted word; on reaching TIMEOUT it SHALL pulse o_flush for one cycle, clear the counter, enter IDLE and advance ptr to g+1.
REQ-029 An accepted word SHALL clear the idle counter.
REQ-030 Without DESER_ARB_TIMEOUT_EN, no timeout logic SHALL exist, o_flush SHALL be tied 0, and a stalled owner SHALL hold the grant indefinitely.

Verification
REQ-031 Reset, then i_req=4'b0001 with ch0 sending 0x11,0x22,0x33,0x44 on consecutive cycles -> o_grant=0001 one cycle after request; o_dv high 4 cycles carrying 0x11..0x44 with o_owner=0; o_grant=0 after the 4th word.
REQ-032 i_req=4'b1111 held, every channel streaming -> frame owners 0,1,2,3,0, each frame 4 words, each followed by one IDLE cycle.
REQ-033 Owner ch2, pointer at 3 with i_req=4'b0101 -> next grant goes to ch0 (wrap-around).
REQ-034 i_dv asserted on ch1 while ch2 is granted -> no o_dv, and ch1 data never appears on o_data.
REQ-035 i_reset asserted after 2 of 4 words -> all outputs 0 in the same cycle; after release, i_req=4'b1000 is granted to ch3 and the frame completes normally.
REQ-036 With DESER_ARB_TIMEOUT_EN and TIMEOUT=16, ch1 sends 1 word then stalls -> o_flush pulses once 16 cycles after that word, o_grant clears, and a pending ch2 request is granted next.
